fp_mul_sequencer: RTL
=====================

Name: fp_mul_sequencer

Overview:
- Upstream control stage for the multi-cycle shift-accumulate fp_multiplier.
- Accepts an IEEE-754 single-precision operand pair over a valid/ready handshake and registers it onto the multiplier operand inputs.
- Drives the multiplier's active-high reset for a hold window, then counts out the multiplier's fixed latency. It captures out/of/uf and presents the result on a valid/ready output handshake.
- Zero operands bypass the multiplier entirely.

Parameters:
- WIDTH, 32, operand/result width (single precision only).
- HOLD_CYCLES, 3, cycles mul_rst is held high after accept.
- LATENCY, 40, cycles from mul_rst release to a valid multiplier result.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > max(HOLD_CYCLES, LATENCY).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept an operand pair.
- in_a  in  32  operand M.
- in_b  in  32  operand Q.
- mul_a  out  32  registered operand M to the multiplier.
- mul_b  out  32  registered operand Q to the multiplier.
- mul_rst  out  1  active-high reset to the multiplier.
- mul_out  in  32  multiplier product.
- mul_of  in  1  multiplier overflow flag.
- mul_uf  in  1  multiplier underflow flag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  32  captured product.
- out_of  out  1  captured overflow.
- out_uf  out  1  captured underflow.
- busy  out  1  high in HOLD or RUN.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0.
  - mul_a = mul_b = out_result = 0; out_of = out_uf = out_valid = 0.
  - mul_rst=1, busy=0.
- States: IDLE, HOLD, RUN, DONE. State is a registered FSM; all outputs are registered or decoded directly from state.
- in_ready = (state==IDLE). Accept occurs on a rising edge when in_valid & in_ready.
- IDLE:
  - mul_rst=1.
  - On accept: latch in_a→mul_a and in_b→mul_b, clear counter.
  - Zero detect: an operand is zero if bits[30:0]==0, either sign.
  - If either operand is zero: load out_result=32'h0000_0000 (+0), out_of=0, out_uf=0, go to DONE. The multiplier is not started.
  - Otherwise go to HOLD.
- HOLD:
  - mul_rst=1.
  - Counter increments each cycle. After HOLD_CYCLES cycles, clear counter and go to RUN.
- RUN:
  - mul_rst=0.
  - Counter increments each cycle.
  - On the edge ending the LATENCY-th RUN cycle: capture mul_out/mul_of/mul_uf into out_result/out_of/out_uf and go to DONE.
- DONE:
  - mul_rst=1, out_valid=1.
  - Outputs are held stable until out_valid & out_ready. On that edge go to IDLE; out_valid falls next cycle.
- Latency:
  - Normal path: out_valid rises HOLD_CYCLES+LATENCY edges after the accept edge (43 with defaults).
  - Zero bypass: out_valid rises 1 edge after accept.
- mul_a/mul_b hold their value from accept until the next accept. They are not cleared on DONE→IDLE.
- No overlap: a new pair cannot be accepted in the same cycle a result is consumed. in_ready rises the cycle after the result handshake.
- out_ready asserted while out_valid=0 has no effect.
- Reset mid-operation (any state):
  - Immediate return to IDLE with reset values.
  - Any in-flight result is discarded and never presented.
- Counter must not wrap. Parameter legality is checked by the CNT_W rule above, not at runtime.
- Sign of zero bypass is always +0, per existing multiplier test expectations.

Test Plan:
- Basic path: accept 49072340 × 44520000 with out_ready=1.
  - Expect in_ready=0 and busy=1 through HOLD/RUN.
  - Expect mul_rst high for exactly 3 cycles, then low for 40.
  - Expect out_valid at edge 43 after accept, with out_result=4DDDB5D5, of=0, uf=0.
- Signed operands:
  - C3818000 × 49072340 → out_result=CD08B8A9.
  - 4EA0C8E4 × CE8EF06B → out_result=DDB38CDC.
- Overflow: 7F7FFFF0 × 41A00000 → out_of=1 at out_valid; FF7FFFF0 × 41A00000 → out_of=1.
- Zero bypass: 00000000 × 4EA0C8E4 and CE8EF06B × 80000000.
  - Expect out_valid 1 cycle after accept, out_result=00000000.
  - Expect mul_rst to never deassert.
- Backpressure: out_ready=0 for 5 cycles after out_valid.
  - out_result and flags hold; in_ready stays 0 while in_valid is held high.
  - Raise out_ready: out_valid drops next edge, and in_ready=1 the following cycle.
- Reset mid-RUN: pulse reset low at RUN cycle 20.
  - Expect all outputs to reset values asynchronously and out_valid never asserted for that pair.
  - Expect a following accept of 3F800000 × 4EA0C8E4 → 4EA0C8E4.

Source files
------------

// File: rtl/fp_mul_sequencer.sv
// Control stage for the multi-cycle fp_multiplier: accepts an operand pair, holds the
// multiplier in reset, waits out its latency, then presents the product on a valid/ready port.
module fp_mul_sequencer #(
    parameter int WIDTH       = 32,
    parameter int HOLD_CYCLES = 3,
    parameter int LATENCY     = 40,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic             mul_rst,
    input  logic [WIDTH-1:0] mul_out,
    input  logic             mul_of,
    input  logic             mul_uf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_of,
    output logic             out_uf,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(LATENCY - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             a_zero;
    logic             b_zero;

    // Zero ignores the sign bit, so -0 also takes the bypass.
    assign a_zero = (in_a[WIDTH-2:0] == '0);
    assign b_zero = (in_b[WIDTH-2:0] == '0);

    // The multiplier only runs in RUN; every other state keeps it parked in reset.
    assign mul_rst   = (state != RUN);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == HOLD) || (state == RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            out_result <= '0;
            out_of     <= 1'b0;
            out_uf     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        mul_a <= in_a;
                        mul_b <= in_b;
                        count <= '0;
                        if (a_zero || b_zero) begin
                            out_result <= '0;
                            out_of     <= 1'b0;
                            out_uf     <= 1'b0;
                            state      <= DONE;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (count == HOLD_LAST) begin
                        count <= '0;
                        state <= RUN;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                RUN: begin
                    // Capture on the edge that closes the final latency cycle.
                    if (count == RUN_LAST) begin
                        out_result <= mul_out;
                        out_of     <= mul_of;
                        out_uf     <= mul_uf;
                        state      <= DONE;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
